// File: rtl/draw_layer_arbiter.sv
// draw_layer_arbiter
//   Runs the per-object draw engines once per frame, lowest layer index first
//   (so layer 0 ends up bottom-most), and forwards the granted engine's pixel
//   stream to the single VGA-adapter write port. A colour-key check can turn
//   a pixel into "no write" on a per-layer basis, and a per-layer watchdog
//   aborts an engine that never reports done.
//
// Ports
//   clk, resetn        clock; synchronous reset, active HIGH despite the name
//   go                 frame-start request, only honoured while idle
//   layer_mask         layers to draw this frame (latched on accepted go)
//   trans_en           layers using the colour key (latched on accepted go)
//   start_o            one-cycle start pulse per engine
//   done_i             per-engine done (level or pulse)
//   x_i/y_i/color_i    packed engine pixel buses, layer i in slice i
//   we_i               per-engine write enables
//   X_out/Y_out/
//   Color_out/writeEn  registered pixel write towards the VGA adapter
//   busy               high whenever a frame is in progress
//   frame_done         one-cycle pulse at the end of the frame
//   grant_idx          currently granted layer, 0 when idle
//   timeout_flags      sticky per-layer abort flags, cleared on accepted go
module draw_layer_arbiter #(
  parameter int          NUM_LAYERS  = 6,
  parameter int          IDX_W       = 3,
  parameter int          TIMEOUT     = 131071,
  parameter int          TO_W        = 17,
  parameter logic [11:0] TRANSPARENT = 12'h000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     go,
  input  logic [NUM_LAYERS-1:0]    layer_mask,
  input  logic [NUM_LAYERS-1:0]    trans_en,
  output logic [NUM_LAYERS-1:0]    start_o,
  input  logic [NUM_LAYERS-1:0]    done_i,
  input  logic [9*NUM_LAYERS-1:0]  x_i,
  input  logic [8*NUM_LAYERS-1:0]  y_i,
  input  logic [12*NUM_LAYERS-1:0] color_i,
  input  logic [NUM_LAYERS-1:0]    we_i,
  output logic [8:0]               X_out,
  output logic [7:0]               Y_out,
  output logic [11:0]              Color_out,
  output logic                     writeEn,
  output logic                     busy,
  output logic                     frame_done,
  output logic [IDX_W-1:0]         grant_idx,
  output logic [NUM_LAYERS-1:0]    timeout_flags
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                state_r;
  logic [NUM_LAYERS-1:0] mask_r;
  logic [NUM_LAYERS-1:0] trans_r;
  logic [TO_W-1:0]       wdog_r;

  logic [IDX_W:0]        first_s;   // {valid, index} of lowest bit in layer_mask
  logic [IDX_W:0]        next_s;    // {valid, index} of next latched layer above grant
  logic [TO_W-1:0]       wdog_nx_s;
  logic                  timeout_s;
  logic [8:0]            x_sel_s;
  logic [7:0]            y_sel_s;
  logic [11:0]           color_sel_s;
  logic                  we_sel_s;
  logic                  done_sel_s;
  logic                  trans_sel_s;
  logic                  pix_we_s;

  // Priority encoder: lowest set bit of m at index >= lo, as {valid, index}.
  function automatic logic [IDX_W:0] scan_from(input logic [NUM_LAYERS-1:0] m,
                                               input int lo);
    logic [IDX_W:0] r;
    r = {(IDX_W+1){1'b0}};
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (m[i] && (i >= lo)) begin
        r = {1'b1, IDX_W'(i)};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // One-hot decode of a layer index.
  function automatic logic [NUM_LAYERS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_LAYERS-1:0] r;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      r[i] = (idx == IDX_W'(i));
    end
    return r;
  endfunction

  // Grant scans, saturating watchdog and selection of the granted engine's signals.
  always_comb begin
    first_s     = scan_from(layer_mask, 0);
    next_s      = scan_from(mask_r, int'(grant_idx) + 1);
    // The next value counts the WAIT cycle now ending, so a hung layer gets
    // exactly TIMEOUT WAIT cycles before it is dropped.
    wdog_nx_s   = (wdog_r == TO_W'(TIMEOUT)) ? wdog_r : wdog_r + TO_W'(1);
    timeout_s   = (wdog_nx_s == TO_W'(TIMEOUT));
    x_sel_s     = 9'd0;
    y_sel_s     = 8'd0;
    color_sel_s = 12'd0;
    we_sel_s    = 1'b0;
    done_sel_s  = 1'b0;
    trans_sel_s = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      x_sel_s     = (grant_idx == IDX_W'(i)) ? x_i[9*i +: 9]      : x_sel_s;
      y_sel_s     = (grant_idx == IDX_W'(i)) ? y_i[8*i +: 8]      : y_sel_s;
      color_sel_s = (grant_idx == IDX_W'(i)) ? color_i[12*i +: 12] : color_sel_s;
      we_sel_s    = (grant_idx == IDX_W'(i)) ? we_i[i]             : we_sel_s;
      done_sel_s  = (grant_idx == IDX_W'(i)) ? done_i[i]           : done_sel_s;
      trans_sel_s = (grant_idx == IDX_W'(i)) ? trans_r[i]          : trans_sel_s;
    end
    // Colour key is tested on the live input colour, not on Color_out.
    pix_we_s = we_sel_s & ~(trans_sel_s & (color_sel_s == TRANSPARENT));
  end

  // Frame sequencer FSM with registered pixel path and status outputs.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_r       <= ST_IDLE;
      mask_r        <= {NUM_LAYERS{1'b0}};
      trans_r       <= {NUM_LAYERS{1'b0}};
      wdog_r        <= {TO_W{1'b0}};
      start_o       <= {NUM_LAYERS{1'b0}};
      X_out         <= 9'd0;
      Y_out         <= 8'd0;
      Color_out     <= 12'd0;
      writeEn       <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      grant_idx     <= {IDX_W{1'b0}};
      timeout_flags <= {NUM_LAYERS{1'b0}};
    end else begin
      start_o    <= {NUM_LAYERS{1'b0}};
      frame_done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          writeEn <= 1'b0;
          if (go) begin
            mask_r        <= layer_mask;
            trans_r       <= trans_en;
            timeout_flags <= {NUM_LAYERS{1'b0}};
            busy          <= 1'b1;
            if (first_s[IDX_W]) begin
              grant_idx <= first_s[IDX_W-1:0];
              start_o   <= onehot(first_s[IDX_W-1:0]);
              state_r   <= ST_START;
            end else begin
              frame_done <= 1'b1;
              state_r    <= ST_DONE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_START: begin
          X_out     <= x_sel_s;
          Y_out     <= y_sel_s;
          Color_out <= color_sel_s;
          writeEn   <= pix_we_s;
          wdog_r    <= {TO_W{1'b0}};
          state_r   <= ST_WAIT;
        end
        ST_WAIT: begin
          // A pixel arriving alongside done is still forwarded.
          X_out     <= x_sel_s;
          Y_out     <= y_sel_s;
          Color_out <= color_sel_s;
          writeEn   <= pix_we_s;
          wdog_r    <= wdog_nx_s;
          if (done_sel_s || timeout_s) begin
            // done takes priority over a simultaneous timeout: no flag.
            if (!done_sel_s) begin
              timeout_flags <= timeout_flags | onehot(grant_idx);
            end else begin
              timeout_flags <= timeout_flags;
            end
            if (next_s[IDX_W]) begin
              grant_idx <= next_s[IDX_W-1:0];
              start_o   <= onehot(next_s[IDX_W-1:0]);
              state_r   <= ST_START;
            end else begin
              frame_done <= 1'b1;
              state_r    <= ST_DONE;
            end
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_DONE: begin
          writeEn   <= 1'b0;
          busy      <= 1'b0;
          grant_idx <= {IDX_W{1'b0}};
          state_r   <= ST_IDLE;
        end
        default: begin
          writeEn   <= 1'b0;
          busy      <= 1'b0;
          grant_idx <= {IDX_W{1'b0}};
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_draw_layer_arbiter.sv
// Directed testbench for draw_layer_arbiter (TIMEOUT shortened to 20).
// Engine models answer done 10 cycles after their start pulse unless the
// layer is in manual mode, where the main sequence drives done directly.
module tb_draw_layer_arbiter;
  localparam int NL = 6;
  localparam int IW = 3;

  logic          clk;
  logic          resetn;
  logic          go;
  logic [NL-1:0] layer_mask;
  logic [NL-1:0] trans_en;
  logic [NL-1:0] start_o;
  logic [NL-1:0] done_i;
  logic [9*NL-1:0]  x_i;
  logic [8*NL-1:0]  y_i;
  logic [12*NL-1:0] color_i;
  logic [NL-1:0] we_i;
  logic [8:0]    X_out;
  logic [7:0]    Y_out;
  logic [11:0]   Color_out;
  logic          writeEn;
  logic          busy;
  logic          frame_done;
  logic [IW-1:0] grant_idx;
  logic [NL-1:0] timeout_flags;

  logic [NL-1:0] manual;
  logic [NL-1:0] man_done;

  int checks = 0;
  int errors = 0;

  // Monitor state (written only by the monitor/engine process)
  int          cyc = 0;
  int          start_cnt = 0;
  int          fd_cnt = 0;
  int          fd_cyc = 0;
  int          d5_cyc = -1;
  logic [31:0] sseq = 32'd0;
  logic [31:0] gseq = 32'd0;
  int          st_cyc [NL];
  int          ecnt [NL];

  int fd0;
  int s0;

  draw_layer_arbiter #(.TIMEOUT(20)) dut (
    .clk(clk), .resetn(resetn), .go(go), .layer_mask(layer_mask),
    .trans_en(trans_en), .start_o(start_o), .done_i(done_i), .x_i(x_i),
    .y_i(y_i), .color_i(color_i), .we_i(we_i), .X_out(X_out), .Y_out(Y_out),
    .Color_out(Color_out), .writeEn(writeEn), .busy(busy),
    .frame_done(frame_done), .grant_idx(grant_idx),
    .timeout_flags(timeout_flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame(input int max_cyc, input string tag);
    int k;
    k = 0;
    while (frame_done !== 1'b1 && k < max_cyc) begin
      step();
      k++;
    end
    check(tag, {63'd0, frame_done}, 64'd1);
  endtask

  // Monitor (reads first, so done_i seen here is what the DUT sampled at the
  // preceding edge) followed by the engine models.
  initial begin
    done_i = '0;
    for (int i = 0; i < NL; i++) begin
      ecnt[i]   = 0;
      st_cyc[i] = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NL; i++) begin
        if (start_o[i]) begin
          start_cnt++;
          sseq      = (sseq << 3) | 32'(i);
          st_cyc[i] = cyc;
        end
      end
      if (start_o != '0) gseq = (gseq << 3) | 32'(grant_idx);
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      if (done_i[5]) d5_cyc = cyc;
      for (int i = 0; i < NL; i++) begin
        if (manual[i]) begin
          done_i[i] = man_done[i];
        end else if (start_o[i]) begin
          ecnt[i]   = 10;
          done_i[i] = 1'b0;
        end else if (ecnt[i] == 1) begin
          ecnt[i]   = 0;
          done_i[i] = 1'b1;
        end else begin
          if (ecnt[i] > 1) ecnt[i]--;
          done_i[i] = 1'b0;
        end
      end
    end
  end

  initial begin
    resetn = 1'b1; go = 1'b0; layer_mask = '0; trans_en = '0;
    manual = '0; man_done = '0; x_i = '0; y_i = '0; color_i = '0; we_i = '0;

    // ---- 1: reset, full frame over all six layers
    step(); step();
    check("reset_outputs", {17'd0, start_o, X_out, Y_out, Color_out, writeEn,
                            busy, frame_done, grant_idx, timeout_flags}, 64'd0);
    resetn = 1'b0; layer_mask = 6'b111111; go = 1'b1;
    fd0 = fd_cnt; s0 = start_cnt;
    step(); go = 1'b0;
    check("t1_first_start", {58'd0, start_o}, 64'd1);
    check("t1_busy_start", {63'd0, busy}, 64'd1);
    wait_frame(300, "t1_frame_done_seen");
    check("t1_busy_in_done", {63'd0, busy}, 64'd1);
    step();
    check("t1_busy_fall", {63'd0, busy}, 64'd0);
    check("t1_fd_once", 64'(fd_cnt - fd0), 64'd1);
    check("t1_start_cnt", 64'(start_cnt - s0), 64'd6);
    check("t1_start_order", {32'd0, sseq & 32'o777777}, {32'd0, 32'o012345});
    check("t1_flags", {58'd0, timeout_flags}, 64'd0);
    check("t1_grant_idle", {61'd0, grant_idx}, 64'd0);

    // ---- 2: sparse mask 100101
    layer_mask = 6'b100101; go = 1'b1; s0 = start_cnt;
    step(); go = 1'b0;
    wait_frame(200, "t2_frame_done_seen");
    step();
    check("t2_start_cnt", 64'(start_cnt - s0), 64'd3);
    check("t2_start_order", {32'd0, sseq & 32'o777}, {32'd0, 32'o025});
    check("t2_grant_order", {32'd0, gseq & 32'o777}, {32'd0, 32'o025});
    check("t2_fd_after_done5", 64'(fd_cyc), 64'(d5_cyc));

    // ---- 3: colour key on layer 1; layer 0 junk must be ignored
    manual = 6'b000010; layer_mask = 6'b000010; trans_en = 6'b000010;
    x_i[8:0] = 9'h1FF; color_i[11:0] = 12'hABC; we_i[0] = 1'b1;
    go = 1'b1;
    step(); go = 1'b0;
    x_i[17:9] = 9'd100; y_i[15:8] = 8'd50; color_i[23:12] = 12'h000; we_i[1] = 1'b1;
    step();
    check("t3_key_blocks", {63'd0, writeEn}, 64'd0);
    check("t3_x_fwd", {55'd0, X_out}, 64'd100);
    check("t3_y_fwd", {56'd0, Y_out}, 64'd50);
    color_i[23:12] = 12'hFC0; x_i[17:9] = 9'd101;
    step();
    check("t3_key_pass_we", {63'd0, writeEn}, 64'd1);
    check("t3_color_fwd", {52'd0, Color_out}, 64'hFC0);
    check("t3_x_fwd2", {55'd0, X_out}, 64'd101);
    color_i[23:12] = 12'h123; man_done[1] = 1'b1;
    step();
    check("t3_fd_with_pixel", {63'd0, frame_done}, 64'd1);
    check("t3_pixel_with_done_we", {63'd0, writeEn}, 64'd1);
    check("t3_pixel_with_done_col", {52'd0, Color_out}, 64'h123);
    man_done[1] = 1'b0; we_i[1] = 1'b0;
    step();
    check("t3_idle_we", {63'd0, writeEn}, 64'd0);
    check("t3_idle_hold_col", {52'd0, Color_out}, 64'h123);
    trans_en = 6'b000000; go = 1'b1;
    step(); go = 1'b0;
    color_i[23:12] = 12'h000; we_i[1] = 1'b1;
    step();
    check("t3_no_key_we", {63'd0, writeEn}, 64'd1);
    man_done[1] = 1'b1;
    step();
    man_done[1] = 1'b0; we_i = '0;
    step();

    // ---- 4: layer 3 hangs and is aborted; stray done on layer 4 is ignored
    manual = 6'b001000; man_done = '0; layer_mask = 6'b011000; go = 1'b1;
    fd0 = fd_cnt;
    step(); go = 1'b0;
    check("t4_start3", {58'd0, start_o}, 64'h08);
    check("t4_grant3", {61'd0, grant_idx}, 64'd3);
    step(); step(); step();
    manual[4] = 1'b1; man_done[4] = 1'b1;
    step();
    man_done[4] = 1'b0; manual[4] = 1'b0;
    wait_frame(200, "t4_frame_done_seen");
    step();
    check("t4_flags", {58'd0, timeout_flags}, 64'h08);
    check("t4_abort_gap", 64'(st_cyc[4] - st_cyc[3]), 64'd21);
    check("t4_fd_once", 64'(fd_cnt - fd0), 64'd1);
    // done in the very cycle the watchdog expires: done wins, flags cleared on go
    layer_mask = 6'b001000; go = 1'b1;
    step(); go = 1'b0;
    check("t4_flag_cleared", {58'd0, timeout_flags}, 64'd0);
    repeat (20) step();
    man_done[3] = 1'b1;
    step();
    check("t4_done_wins_fd", {63'd0, frame_done}, 64'd1);
    check("t4_done_wins_flag", {58'd0, timeout_flags}, 64'd0);
    man_done[3] = 1'b0;
    step();

    // ---- 5: go ignored while busy; empty mask
    manual = '0; layer_mask = 6'b000001; s0 = start_cnt; fd0 = fd_cnt;
    go = 1'b1;
    step(); go = 1'b0;
    step(); step(); step();
    go = 1'b1;
    step(); go = 1'b0;
    wait_frame(100, "t5_frame_done_seen");
    go = 1'b1;
    step(); go = 1'b0;
    step(); step();
    check("t5_no_restart_busy", {63'd0, busy}, 64'd0);
    check("t5_start_cnt", 64'(start_cnt - s0), 64'd1);
    check("t5_fd_once", 64'(fd_cnt - fd0), 64'd1);
    layer_mask = 6'b000000; s0 = start_cnt; fd0 = fd_cnt;
    go = 1'b1;
    step(); go = 1'b0;
    check("t5_empty_fd", {63'd0, frame_done}, 64'd1);
    check("t5_empty_start", {58'd0, start_o}, 64'd0);
    step();
    check("t5_empty_fd_pulse", {63'd0, frame_done}, 64'd0);
    check("t5_empty_idle", {63'd0, busy}, 64'd0);
    step();
    check("t5_empty_no_starts", 64'(start_cnt - s0), 64'd0);

    // ---- 6: reset in WAIT of layer 2
    manual = 6'b000100; man_done = '0; layer_mask = 6'b000100; go = 1'b1;
    step(); go = 1'b0;
    we_i[2] = 1'b1; color_i[35:24] = 12'h0F0; x_i[26:18] = 9'd7;
    step(); step();
    check("t6_pre_write", {63'd0, writeEn}, 64'd1);
    fd0 = fd_cnt;
    resetn = 1'b1;
    step();
    check("t6_reset_outputs", {17'd0, start_o, X_out, Y_out, Color_out, writeEn,
                               busy, frame_done, grant_idx, timeout_flags}, 64'd0);
    resetn = 1'b0;
    step(); step();
    check("t6_no_fd", 64'(fd_cnt - fd0), 64'd0);
    check("t6_idle", {63'd0, busy}, 64'd0);
    we_i = '0; manual = '0; layer_mask = 6'b000101; go = 1'b1;
    step(); go = 1'b0;
    check("t6_restart_layer0", {58'd0, start_o}, 64'd1);
    wait_frame(100, "t6_frame_done_seen");
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
